branch_predictor: RTL and testbench



---
 rtl/cpu_types_pkg.sv | 8 +
 rtl/sat_counter.sv | 20 ++
 rtl/branch_predictor.sv | 99 +++++++++
 tb/tb_branch_predictor.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared CPU types and branch predictor constants
// word_t: PC/target word; btb_state_t: predictor clear-engine states;
// BTB_ENTRY_DEF: default number of BTB entries.
package cpu_types_pkg;
  typedef logic [31:0] word_t;
  typedef enum logic {BTB_IDLE, BTB_CLEAR} btb_state_t;
  localparam int BTB_ENTRY_DEF = 16;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: combinational next-state of a saturating direction counter
// inc/dec step the count within [0, 2^CTR_BITS-1]; load overrides with load_val;
// cur_in is the present count, next_out the resulting count.
module sat_counter #(
  parameter int CTR_BITS = 2
) (
  input  logic                inc,
  input  logic                dec,
  input  logic                load,
  input  logic [CTR_BITS-1:0] load_val,
  input  logic [CTR_BITS-1:0] cur_in,
  output logic [CTR_BITS-1:0] next_out
);
  localparam logic [CTR_BITS-1:0] MAX = '1;
  always_comb
    next_out = load ? load_val
             : inc  ? (cur_in == MAX ? cur_in : cur_in + CTR_BITS'(1))
             : dec  ? (cur_in == '0  ? cur_in : cur_in - CTR_BITS'(1))
             : cur_in;
endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB with saturating-counter direction prediction
// CLK/nRST: clock, async active-low reset
// lookup_pc -> pred_hit/pred_taken/pred_target: zero-latency fetch prediction
// upd_*: resolved branch feedback; clr_req/busy: walking table clear
// lookups/mispredicts: wrapping performance counters
module branch_predictor
  import cpu_types_pkg::*;
#(
  parameter int ENTRIES  = BTB_ENTRY_DEF,
  parameter int CTR_BITS = 2,
  parameter int WORD_W   = 32,
  parameter int CNT_W    = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic [WORD_W-1:0] lookup_pc,
  output logic              pred_hit,
  output logic              pred_taken,
  output logic [WORD_W-1:0] pred_target,
  input  logic              upd_en,
  input  logic [WORD_W-1:0] upd_pc,
  input  logic              upd_taken,
  input  logic [WORD_W-1:0] upd_target,
  input  logic              upd_mispredict,
  input  logic              clr_req,
  output logic              busy,
  output logic [CNT_W-1:0]  lookups,
  output logic [CNT_W-1:0]  mispredicts
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = WORD_W - IDX_W - 2;
  localparam logic [CTR_BITS-1:0] WEAK_T = CTR_BITS'(1) << (CTR_BITS - 1);
  typedef struct packed {
    logic                valid;
    logic [TAG_W-1:0]    tag;
    logic [WORD_W-1:0]   target;
    logic [CTR_BITS-1:0] ctr;
  } entry_t;
  entry_t              tbl [ENTRIES];
  entry_t              lk_e, up_e;
  btb_state_t          state;
  logic [IDX_W-1:0]    clr_idx, lk_idx, up_idx;
  logic [TAG_W-1:0]    lk_tag, up_tag;
  logic [CTR_BITS-1:0] ctr_next;
  logic                up_hit, do_upd, unused_ok;
  assign lk_idx      = lookup_pc[IDX_W+1:2];
  assign lk_tag      = lookup_pc[WORD_W-1:IDX_W+2];
  assign up_idx      = upd_pc[IDX_W+1:2];
  assign up_tag      = upd_pc[WORD_W-1:IDX_W+2];
  assign unused_ok   = ^upd_pc[1:0];
  assign lk_e        = tbl[lk_idx];
  assign up_e        = tbl[up_idx];
  assign busy        = state == BTB_CLEAR;
  assign pred_hit    = !busy && lk_e.valid && lk_e.tag == lk_tag;
  assign pred_taken  = pred_hit && lk_e.ctr[CTR_BITS-1];
  assign pred_target = pred_hit ? lk_e.target : lookup_pc + WORD_W'(4);
  assign up_hit      = up_e.valid && up_e.tag == up_tag;
  // a clear request in the same cycle takes priority and drops the update
  assign do_upd      = upd_en && !busy && !clr_req && (up_hit || upd_taken);
  // a miss can only reach the counter when taken, so load means allocate
  sat_counter #(.CTR_BITS(CTR_BITS)) u_ctr (
    .inc      (upd_taken),
    .dec      (!upd_taken),
    .load     (!up_hit),
    .load_val (WEAK_T),
    .cur_in   (up_e.ctr),
    .next_out (ctr_next)
  );
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) begin
      state   <= BTB_IDLE;
      clr_idx <= '0;
    end else if (busy) begin
      clr_idx <= clr_idx + IDX_W'(1);
      if (clr_idx == IDX_W'(ENTRIES - 1)) state <= BTB_IDLE;
    end else if (clr_req) begin
      state   <= BTB_CLEAR;
      clr_idx <= '0;
    end
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) begin
      for (int i = 0; i < ENTRIES; i++) tbl[i] <= '0;
    end else if (busy) begin
      tbl[clr_idx].valid <= 1'b0;
    end else if (do_upd) begin
      tbl[up_idx] <= '{valid:  1'b1,
                       tag:    up_tag,
                       target: (up_hit && !upd_taken) ? up_e.target : upd_target,
                       ctr:    ctr_next};
    end
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) begin
      lookups     <= '0;
      mispredicts <= '0;
    end else begin
      lookups     <= lookups + CNT_W'(pred_hit);
      mispredicts <= mispredicts + CNT_W'(upd_en && upd_mispredict);
    end
endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: randomized + directed check of two predictor configurations against a reference model
module tb_branch_predictor;
  import cpu_types_pkg::*;
  logic  CLK = 1'b0, nRST = 1'b0;
  word_t lookup_pc, upd_pc, upd_target;
  logic  upd_en, upd_taken, upd_mispredict, clr_req;
  logic  hit [2], tk [2], bz [2];
  word_t tg [2], lk [2], mp [2];
  int    checks = 0, failures = 0;
  always #5 CLK = ~CLK;
  branch_predictor dut0 (
    .CLK(CLK), .nRST(nRST), .lookup_pc(lookup_pc),
    .pred_hit(hit[0]), .pred_taken(tk[0]), .pred_target(tg[0]),
    .upd_en(upd_en), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_mispredict(upd_mispredict), .clr_req(clr_req), .busy(bz[0]),
    .lookups(lk[0]), .mispredicts(mp[0]));
  branch_predictor #(.ENTRIES(4), .CTR_BITS(1)) dut1 (
    .CLK(CLK), .nRST(nRST), .lookup_pc(lookup_pc),
    .pred_hit(hit[1]), .pred_taken(tk[1]), .pred_target(tg[1]),
    .upd_en(upd_en), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_mispredict(upd_mispredict), .clr_req(clr_req), .busy(bz[1]),
    .lookups(lk[1]), .mispredicts(mp[1]));
  // reference model: per configuration, index/tag come from word address arithmetic
  int unsigned ne [2] = '{16, 4};
  int          cb [2] = '{2, 1};
  bit          mv [2][16];
  int unsigned mt [2][16];
  word_t       mg [2][16];
  int          mc [2][16];
  int          bl [2];
  word_t       mlk [2], mmp [2];
  function automatic int ix(int k, word_t pc);
    return int'((pc >> 2) % ne[k]);
  endfunction
  function automatic int unsigned tag_of(int k, word_t pc);
    return (pc >> 2) / ne[k];
  endfunction
  function automatic bit e_hit(int k, word_t pc);
    return bl[k] == 0 && mv[k][ix(k, pc)] && mt[k][ix(k, pc)] == tag_of(k, pc);
  endfunction
  function automatic bit e_tk(int k, word_t pc);
    return e_hit(k, pc) && mc[k][ix(k, pc)] >= (1 << (cb[k] - 1));
  endfunction
  function automatic word_t e_tg(int k, word_t pc);
    return e_hit(k, pc) ? mg[k][ix(k, pc)] : pc + 4;
  endfunction
  task automatic chk(string name, word_t act, word_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge nRST)
    for (int k = 0; k < 2; k++) begin
      for (int j = 0; j < 16; j++) begin mv[k][j] = 0; mt[k][j] = 0; mg[k][j] = 0; mc[k][j] = 0; end
      bl[k] = 0; mlk[k] = 0; mmp[k] = 0;
    end
  always @(posedge CLK)
    if (nRST)
      for (int k = 0; k < 2; k++) begin
        int i;
        bit h;
        i = ix(k, upd_pc);
        if (e_hit(k, lookup_pc)) mlk[k]++;
        if (upd_en && upd_mispredict) mmp[k]++;
        if (bl[k] > 0) bl[k]--;
        else if (clr_req) begin
          for (int j = 0; j < 16; j++) mv[k][j] = 0;
          bl[k] = int'(ne[k]);
        end else if (upd_en) begin
          h = mv[k][i] && mt[k][i] == tag_of(k, upd_pc);
          if (h && upd_taken) begin
            mc[k][i] = (mc[k][i] + 1 > (1 << cb[k]) - 1) ? (1 << cb[k]) - 1 : mc[k][i] + 1;
            mg[k][i] = upd_target;
          end else if (h) mc[k][i] = (mc[k][i] > 0) ? mc[k][i] - 1 : 0;
          else if (upd_taken) begin
            mv[k][i] = 1; mt[k][i] = tag_of(k, upd_pc); mg[k][i] = upd_target; mc[k][i] = 1 << (cb[k] - 1);
          end
        end
      end
  always @(negedge CLK)
    if (nRST)
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("k%0d pred_hit", k), word_t'(hit[k]), word_t'(e_hit(k, lookup_pc)));
        chk($sformatf("k%0d pred_taken", k), word_t'(tk[k]), word_t'(e_tk(k, lookup_pc)));
        chk($sformatf("k%0d pred_target", k), tg[k], e_tg(k, lookup_pc));
        chk($sformatf("k%0d busy", k), word_t'(bz[k]), word_t'(bl[k] > 0));
        chk($sformatf("k%0d lookups", k), lk[k], mlk[k]);
        chk($sformatf("k%0d mispredicts", k), mp[k], mmp[k]);
      end
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask
  task automatic idle();
    upd_en = 0; upd_pc = 0; upd_taken = 0; upd_target = 0; upd_mispredict = 0; clr_req = 0;
  endtask
  task automatic upd(word_t pc, logic t, word_t tgt);
    upd_en = 1; upd_pc = pc; upd_taken = t; upd_target = tgt;
    tick();
    idle();
    #1;
  endtask
  function automatic word_t rpc();
    word_t p;
    p = (word_t'($urandom_range(0, 127)) << 2) | word_t'($urandom_range(0, 3));
    if ($urandom_range(0, 7) == 0) p |= $urandom & 32'hFFFF_0000;
    return p;
  endfunction
  initial begin
    int n;
    word_t prev;
    idle();
    lookup_pc = 32'h40;
    #12;
    for (int k = 0; k < 2; k++) begin
      chk("reset hit", word_t'(hit[k]), 0);
      chk("reset taken", word_t'(tk[k]), 0);
      chk("reset target", tg[k], 32'h44);
      chk("reset lookups", lk[k], 0);
      chk("reset busy", word_t'(bz[k]), 0);
    end
    tick();
    nRST = 1;
    upd(32'h40, 1, 32'h100);
    chk("alloc hit", word_t'(hit[0]), 1);
    chk("alloc taken", word_t'(tk[0]), 1);
    chk("alloc target", tg[0], 32'h100);
    chk("alloc taken 1b", word_t'(tk[1]), 1);
    prev = lk[0];
    tick();
    chk("lookups step", lk[0], prev + 1);
    upd(32'h40, 0, 32'h0);
    chk("nt1 taken", word_t'(tk[0]), 0);
    chk("nt1 target kept", tg[0], 32'h100);
    chk("nt1 taken 1b", word_t'(tk[1]), 0);
    upd(32'h40, 0, 32'h0);
    upd(32'h40, 0, 32'h0);
    upd(32'h40, 1, 32'h100);
    chk("t after floor", word_t'(tk[0]), 0);
    chk("t after floor 1b", word_t'(tk[1]), 1);
    repeat (3) upd(32'h40, 1, 32'h100);
    upd(32'h40, 0, 32'h0);
    chk("saturated then nt", word_t'(tk[0]), 1);
    upd(32'h80, 1, 32'h200);
    chk("alias old miss", tg[0], 32'h44);
    lookup_pc = 32'h80;
    #1;
    chk("alias new hit", word_t'(hit[0]), 1);
    chk("alias new target", tg[0], 32'h200);
    upd_en = 1; upd_pc = 32'hC0; upd_taken = 1; upd_target = 32'h300; upd_mispredict = 1; clr_req = 1;
    tick();
    idle();
    n = 0;
    while (bz[0] && n < 40) begin n++; tick(); end
    chk("clear busy cycles", n, 16);
    lookup_pc = 32'hC0;
    #1;
    chk("dropped update miss", word_t'(hit[0]), 0);
    for (int c = 0; c < 1500; c++) begin
      lookup_pc = rpc();
      upd_en = $urandom_range(0, 1);
      upd_pc = rpc();
      upd_taken = $urandom_range(0, 2) != 0;
      upd_target = $urandom & 32'hFFFF_FFFC;
      upd_mispredict = $urandom_range(0, 3) == 0;
      clr_req = $urandom_range(0, 99) == 0;
      tick();
    end
    idle();
    for (int c = 0; c < 8; c++) upd(32'h100 + 32'(c * 4), 1, 32'h500);
    clr_req = 1;
    upd_en = 1; upd_mispredict = 1; upd_pc = 32'h104; upd_taken = 1;
    tick();
    idle();
    repeat (4) tick();
    #1 nRST = 0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("mid-clear reset busy", word_t'(bz[k]), 0);
      chk("mid-clear reset lookups", lk[k], 0);
      chk("mid-clear reset mispredicts", mp[k], 0);
    end
    tick();
    #2 nRST = 1;
    for (int c = 0; c < 8; c++) begin
      lookup_pc = 32'h100 + 32'(c * 4);
      tick();
      chk("post reset miss", word_t'(hit[0] | hit[1]), 0);
    end
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
